operand_stack: RTL and testbench
================================

// Module: operand_stack
// PURPOSE
//   LIFO operand stack for the stack-machine datapath. Executes the push/pop/tos
//   commands issued by the multicycle controller.
//   Returns popped or peeked operands on a registered output, together with a zero flag used by jz.
//   Sits between controller, ALU/MDR mux (push source) and ALU B/memory write path.
// PARAMETERS
//   WIDTH  8   data word width (bits)
//   DEPTH  16  number of entries; power of two, >=2
// PORTS
//   clk        in   1               rising-edge clock, single clock domain
//   rst_n      in   1               asynchronous, active-low reset
//   push       in   1               write push_data on top (1-cycle pulse per op)
//   pop        in   1               remove top entry, copy it to dout
//   tos        in   1               peek: copy top entry to dout, no removal
//   push_data  in   WIDTH           data to push (ALU result or MDR)
//   dout       out  WIDTH           registered read data (popped/peeked value)
//   zero       out  1               dout == 0 (combinational from dout)
//   count      out  $clog2(DEPTH)+1 current number of entries
//   empty      out  1               count == 0
//   full       out  1               count == DEPTH
//   err_ovf    out  1               sticky: push attempted while full
//   err_unf    out  1               sticky: pop/tos attempted while empty
// BEHAVIOUR
//   - Reset (async assert): sp=0, dout=0, empty=1, full=0, err_*=0. Array contents are not reset.
//   - All updates on posedge clk. dout is valid the cycle after the command (latency 1).
//     dout holds its value otherwise.
//   - Top entry is mem[sp-1]. sp ranges 0..DEPTH, with no wrap-around.
//   - Command decode (priority as listed):
//     * push & pop, !empty: dout<=mem[sp-1]; mem[sp-1]<=push_data; sp unchanged (replace-top).
//     * push & pop, empty:  pop is an underflow (dout holds); the push proceeds normally.
//     * pop (tos ignored if also set), !empty: dout<=mem[sp-1]; sp<=sp-1.
//     * tos only, !empty: dout<=mem[sp-1]; sp unchanged.
//     * push & tos: dout<=old top if !empty; the push proceeds.
//     * push, !full: mem[sp]<=push_data; sp<=sp+1.
//     * push, full: ignored; array and sp unchanged.
//     * pop/tos, empty: ignored; dout holds.
//   - A full stack accepts replace-top (push & pop): sp does not change.
//   - empty, full and count derive from registered sp; no combinational path from the inputs.
//   - Reset mid-operation discards the in-flight command. Stale array data is unreachable since sp=0.
// CONFIGURATION
//   STACK_ERR_EN defined:
//     - err_ovf is set on a rejected push; err_unf is set on a rejected pop/tos.
//     - Both flags are sticky until rst_n; ops issued after an error still execute normally.
//     - A $display warning is emitted in simulation.
//   STACK_ERR_EN undefined:
//     - err_ovf/err_unf are tied 0 and no flag logic is synthesised.
//     - Rejected ops are still silently ignored.
// STRUCTURE
//   - Shared header stack_defs.vh holds the command-encoding localparams:
//     CMD_NOP, CMD_PUSH, CMD_POP, CMD_TOS, CMD_REPL.
//   - It also holds the default WIDTH/DEPTH, shared with the controller and the testbench.
//   - One sub-module, stack_regfile: DEPTH x WIDTH array, one sync write port, one async read port
//     (raddr = sp-1). operand_stack keeps sp, command decode, dout and the flags.
// TESTING
//   1. Reset, then tos -> dout stays 0, empty=1, err_unf=1 (with STACK_ERR_EN).
//   2. push 8'h05, push 8'h03; pop -> dout=8'h03, count=1; pop -> dout=8'h05, empty=1.
//   3. push 8'h07; tos -> dout=8'h07, count=1; pop+push 8'h09 -> dout=8'h07, count=1;
//      tos -> dout=8'h09.
//   4. 16 pushes of 0..15 -> full=1, count=16; 17th push 8'hAA -> ignored, err_ovf=1;
//      pop -> dout=8'h0F.
//   5. push 8'h00; tos -> dout=0, zero=1; push 8'h01; tos -> zero=0.
//   6. Assert rst_n low mid-push (count=3) -> count=0, dout=0, flags cleared asynchronously.

Source files
------------

// File: rtl/operand_stack_pkg.sv
// operand_stack_pkg: shared definitions for the operand stack.
//   - Default WIDTH/DEPTH, shared with the controller and the testbench.
//   - Command encodings CMD_NOP/CMD_PUSH/CMD_POP/CMD_TOS/CMD_REPL.
//   - op_t: decoded per-cycle actions, and decode_op() producing them.
package operand_stack_pkg;

    localparam int unsigned STACK_WIDTH = 8;
    localparam int unsigned STACK_DEPTH = 16;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_PUSH = 3'd1;
    localparam logic [2:0] CMD_POP  = 3'd2;
    localparam logic [2:0] CMD_TOS  = 3'd3;
    localparam logic [2:0] CMD_REPL = 3'd4;

    typedef struct packed {
        logic rd;      // load dout from the current top entry
        logic wr;      // write push_data into the array
        logic wr_top;  // write goes to the top entry (replace) rather than above it
        logic inc;     // sp <= sp + 1
        logic dec;     // sp <= sp - 1
        logic ovf;     // push rejected (stack full)
        logic unf;     // pop/tos rejected (stack empty)
    } op_t;

    // Priority: push&pop (replace) > pop > push (with optional peek) > tos.
    function automatic op_t decode_op(input logic push, input logic pop, input logic tos,
                                      input logic empty, input logic full);
        op_t        op;
        logic [2:0] cmd;
        op = '0;
        if (push && pop)  cmd = CMD_REPL;
        else if (pop)     cmd = CMD_POP;
        else if (push)    cmd = CMD_PUSH;
        else if (tos)     cmd = CMD_TOS;
        else              cmd = CMD_NOP;

        case (cmd)
            CMD_REPL: begin
                if (!empty) begin
                    op.rd     = 1'b1;
                    op.wr     = 1'b1;
                    op.wr_top = 1'b1;
                end else begin
                    // Pop half underflows; an empty stack always has room for the push.
                    op.unf = 1'b1;
                    op.wr  = 1'b1;
                    op.inc = 1'b1;
                end
            end
            CMD_POP: begin
                if (!empty) begin
                    op.rd  = 1'b1;
                    op.dec = 1'b1;
                end else begin
                    op.unf = 1'b1;
                end
            end
            CMD_PUSH: begin
                if (tos) begin
                    if (!empty) op.rd  = 1'b1;
                    else        op.unf = 1'b1;
                end
                if (!full) begin
                    op.wr  = 1'b1;
                    op.inc = 1'b1;
                end else begin
                    op.ovf = 1'b1;
                end
            end
            CMD_TOS: begin
                if (!empty) op.rd  = 1'b1;
                else        op.unf = 1'b1;
            end
            default: ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/operand_stack_regfile.sv
// operand_stack_regfile: DEPTH x WIDTH storage array for the operand stack.
//   clk    in  rising-edge clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address (asynchronous read)
//   rdata  out read data
// Contents are not reset; the stack pointer alone defines which entries are live.
module operand_stack_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack for the stack-machine datapath.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   push       in   push push_data on top
//   pop        in   remove top entry, copy it to dout
//   tos        in   copy top entry to dout without removal
//   push_data  in   data to push
//   dout       out  registered popped/peeked value (latency 1, holds otherwise)
//   zero       out  dout == 0
//   count      out  number of live entries (0..DEPTH)
//   empty      out  count == 0
//   full       out  count == DEPTH
//   err_ovf    out  sticky: push attempted while full
//   err_unf    out  sticky: pop/tos attempted while empty
// Build option: define STACK_ERR_EN to enable the sticky error flags;
// otherwise err_ovf/err_unf are tied low.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned DEPTH = STACK_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     tos,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         dout,
    output logic                     zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     err_ovf,
    output logic                     err_unf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       sp_q, sp_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [WIDTH-1:0]  rdata;
    logic [AW-1:0]     top_addr, waddr;
    op_t               op;

    assign empty = (sp_q == '0);
    assign full  = (sp_q == (AW+1)'(DEPTH));
    assign count = sp_q;
    assign dout  = dout_q;
    assign zero  = (dout_q == '0);

    assign op = decode_op(push, pop, tos, empty, full);

    // With sp == DEPTH the low bits are 0, so the AW-bit subtract wraps to DEPTH-1.
    assign top_addr = sp_q[AW-1:0] - AW'(1);
    assign waddr    = op.wr_top ? top_addr : sp_q[AW-1:0];

    operand_stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (op.wr),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (top_addr),
        .rdata (rdata)
    );

    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        if (op.inc)      sp_d = sp_q + (AW+1)'(1);
        else if (op.dec) sp_d = sp_q - (AW+1)'(1);
        if (op.rd)       dout_d = rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q   <= '0;
            dout_q <= '0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
        end
    end

`ifdef STACK_ERR_EN
    logic err_ovf_q, err_unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_q | op.ovf;
            err_unf_q <= err_unf_q | op.unf;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
`else
    logic unused_err;
    assign unused_err = op.ovf | op.unf;
    assign err_ovf    = 1'b0;
    assign err_unf    = 1'b0;
`endif

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;
    import operand_stack_pkg::*;

    localparam int unsigned W = STACK_WIDTH;
    localparam int unsigned D = STACK_DEPTH;
`ifdef STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 push = 1'b0, pop = 1'b0, tos = 1'b0;
    logic [W-1:0]         push_data = '0;
    logic [W-1:0]         dout;
    logic                 zero, empty, full, err_ovf, err_unf;
    logic [$clog2(D):0]   count;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [W-1:0] q[$];
    logic [W-1:0] dout_m;
    bit           ovf_m, unf_m;

    always #5 clk = ~clk;

    operand_stack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .push_data (push_data),
        .dout      (dout),
        .zero      (zero),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    function automatic void model_clear();
        q.delete();
        dout_m = '0;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
    endfunction

    function automatic void model_op(input logic p, input logic po, input logic t,
                                     input logic [W-1:0] d);
        bit e = (q.size() == 0);
        if (p && po) begin
            if (!e) begin dout_m = q[$]; q[$] = d; end
            else begin unf_m = 1'b1; q.push_back(d); end
        end else if (po) begin
            if (!e) dout_m = q.pop_back();
            else    unf_m = 1'b1;
        end else begin
            if (t) begin
                if (!e) dout_m = q[$];
                else    unf_m = 1'b1;
            end
            if (p) begin
                if (q.size() < D) q.push_back(d);
                else              ovf_m = 1'b1;
            end
        end
    endfunction

    task automatic step(input logic p, input logic po, input logic t, input logic [W-1:0] d);
        @(negedge clk);
        push = p; pop = po; tos = t; push_data = d;
        @(posedge clk);
        #1;
        model_op(p, po, t, d);
        push = 1'b0; pop = 1'b0; tos = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (dout !== 8'h00 || empty !== 1'b1 || full !== 1'b0 || count !== 0) begin
            bad++; $display("FAIL reset_state: dout=%0h empty=%b full=%b count=%0d want 0/1/0/0",
                            dout, empty, full, count);
        end
        total++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            bad++; $display("FAIL reset_err: ovf=%b unf=%b want 0/0", err_ovf, err_unf);
        end
        step(1'b0, 1'b0, 1'b1, '0);  // tos on empty stack
        total++; if (dout !== 8'h00 || empty !== 1'b1) begin
            bad++; $display("FAIL tos_empty: dout=%0h empty=%b want 0/1", dout, empty);
        end
        total++; if (err_unf !== ERR_EN) begin
            bad++; $display("FAIL tos_empty_unf: err_unf=%b want %b", err_unf, ERR_EN);
        end
    endtask

    task automatic test_push_pop();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 8'h05);
        step(1'b1, 1'b0, 1'b0, 8'h03);
        step(1'b0, 1'b1, 1'b0, '0);
        total++; if (dout !== 8'h03 || count !== 1) begin
            bad++; $display("FAIL pop1: dout=%0h count=%0d want 03/1", dout, count);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        total++; if (dout !== 8'h05 || empty !== 1'b1) begin
            bad++; $display("FAIL pop2: dout=%0h empty=%b want 05/1", dout, empty);
        end
    endtask

    task automatic test_tos_replace();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 8'h07);
        step(1'b0, 1'b0, 1'b1, '0);
        total++; if (dout !== 8'h07 || count !== 1) begin
            bad++; $display("FAIL tos_peek: dout=%0h count=%0d want 07/1", dout, count);
        end
        step(1'b1, 1'b1, 1'b0, 8'h09);
        total++; if (dout !== 8'h07 || count !== 1) begin
            bad++; $display("FAIL replace: dout=%0h count=%0d want 07/1", dout, count);
        end
        step(1'b0, 1'b0, 1'b1, '0);
        total++; if (dout !== 8'h09) begin
            bad++; $display("FAIL replace_tos: dout=%0h want 09", dout);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, W'(i));
        total++; if (full !== 1'b1 || count !== 16) begin
            bad++; $display("FAIL fill: full=%b count=%0d want 1/16", full, count);
        end
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        total++; if (count !== 16 || err_ovf !== ERR_EN) begin
            bad++; $display("FAIL overflow: count=%0d err_ovf=%b want 16/%b", count, err_ovf, ERR_EN);
        end
        step(1'b1, 1'b1, 1'b0, 8'h5A);  // replace-top accepted while full
        total++; if (dout !== 8'h0F || count !== 16) begin
            bad++; $display("FAIL full_replace: dout=%0h count=%0d want 0f/16", dout, count);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        total++; if (dout !== 8'h5A || count !== 15 || full !== 1'b0) begin
            bad++; $display("FAIL full_pop: dout=%0h count=%0d full=%b want 5a/15/0",
                            dout, count, full);
        end
    endtask

    task automatic test_zero();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, '0);
        total++; if (dout !== 8'h00 || zero !== 1'b1) begin
            bad++; $display("FAIL zero_set: dout=%0h zero=%b want 0/1", dout, zero);
        end
        step(1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b0, 1'b1, '0);
        total++; if (dout !== 8'h01 || zero !== 1'b0) begin
            bad++; $display("FAIL zero_clr: dout=%0h zero=%b want 1/0", dout, zero);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b1, 1'b0, 1'b0, 8'h33);
        step(1'b0, 1'b0, 1'b1, '0);
        total++; if (count !== 3 || dout !== 8'h33) begin
            bad++; $display("FAIL pre_reset: count=%0d dout=%0h want 3/33", count, dout);
        end
        @(negedge clk);
        push = 1'b1; push_data = 8'h44;
        #2 rst_n = 1'b0;
        #1;
        total++; if (count !== 0 || dout !== 8'h00 || empty !== 1'b1
                     || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            bad++; $display("FAIL async_reset: count=%0d dout=%0h empty=%b ovf=%b unf=%b want 0/0/1/0/0",
                            count, dout, empty, err_ovf, err_unf);
        end
        push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        step(1'b1, 1'b0, 1'b0, 8'h42);
        step(1'b0, 1'b0, 1'b1, '0);
        total++; if (count !== 1 || dout !== 8'h42) begin
            bad++; $display("FAIL post_reset: count=%0d dout=%0h want 1/42", count, dout);
        end
    endtask

    task automatic test_random();
        logic         p, po, t;
        logic [W-1:0] d;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            p  = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 35);
            t  = ($urandom_range(0, 99) < 25);
            d  = W'($urandom);
            step(p, po, t, d);
            total++; if (dout !== dout_m || zero !== (dout_m == '0)) begin
                bad++; $display("FAIL rand_dout[%0d]: dout=%0h zero=%b want %0h", i, dout, zero, dout_m);
            end
            total++; if (count !== q.size() || empty !== (q.size() == 0)
                         || full !== (q.size() == D)) begin
                bad++; $display("FAIL rand_count[%0d]: count=%0d empty=%b full=%b want %0d",
                                i, count, empty, full, q.size());
            end
            total++; if (err_ovf !== (ERR_EN && ovf_m) || err_unf !== (ERR_EN && unf_m)) begin
                bad++; $display("FAIL rand_err[%0d]: ovf=%b unf=%b want %b/%b",
                                i, err_ovf, err_unf, ERR_EN && ovf_m, ERR_EN && unf_m);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_push_pop();
        test_tos_replace();
        test_full();
        test_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
